mem_access_unit: RTL and testbench

- MEM-stage data-memory port controller, the write/issue side of the load/store path.
- Converts a MEM-stage load/store into a word-aligned data-cache request: aligned address, shifted write data, byte enable.
- Holds the request until mem_resp and stalls the pipeline meanwhile.
- Registers read data and byte enable for the MEM/WB register; the WB stage extracts and extends load data from that byte-enable pattern.

---
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory port controller: turns a load/store into a word-aligned dcache
// request, holds it until mem_resp, and registers read data and lane mask for WB.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic [3:0]  byte_enable_o,
    output logic        misaligned_o,
    output logic        timeout_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_mask;
    logic        r_write;
    logic        r_flush;
    logic [31:0] r_cnt;
    logic [31:0] r_rdata;
    logic [3:0]  r_be;

    logic [1:0]  w_off;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic        w_misaligned;
    logic        w_idle;
    logic        w_busy;
    logic        w_issue;
    logic        w_flushed;
    logic        w_timeout;

    assign w_off = addr[1:0];

    always_comb begin
        w_mask       = 4'b0000;
        w_wdata      = 32'h0;
        w_misaligned = 1'b0;
        case (funct3)
            3'b000, 3'b100: begin
                w_mask  = 4'b0001 << w_off;
                w_wdata = {24'h0, rs2_data[7:0]} << {w_off, 3'b000};
            end
            3'b001, 3'b101: begin
                w_mask       = 4'b0011 << w_off;
                w_wdata      = {16'h0, rs2_data[15:0]} << {w_off, 3'b000};
                w_misaligned = addr[0];
            end
            3'b010: begin
                w_mask       = 4'b1111;
                w_wdata      = rs2_data;
                w_misaligned = |w_off;
            end
            default: ;
        endcase
    end

    assign w_idle    = (r_state == IDLE);
    assign w_busy    = (r_state == BUSY);
    assign w_issue   = w_idle & req_valid & ~w_misaligned & ~flush & (|w_mask);
    // A flush arriving in the same cycle as mem_resp still suppresses completion.
    assign w_flushed = r_flush | flush;
    assign w_timeout = w_busy & ~mem_resp & (TIMEOUT_CYCLES != 0)
                     & (r_cnt == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_mask  <= 4'b0000;
            r_write <= 1'b0;
            r_flush <= 1'b0;
            r_cnt   <= 32'h0;
            r_rdata <= 32'h0;
            r_be    <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state <= BUSY;
                        r_addr  <= {addr[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_mask  <= w_mask;
                        r_write <= req_write;
                        r_flush <= 1'b0;
                        r_cnt   <= 32'h0;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        r_flush <= 1'b0;
                        r_cnt   <= 32'h0;
                        if (w_flushed) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DONE;
                            r_rdata <= r_write ? 32'h0 : mem_rdata;
                            r_be    <= r_mask;
                        end
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                        r_flush <= 1'b0;
                        r_cnt   <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                        if (flush) begin
                            r_flush <= 1'b1;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_read        = w_busy & ~r_write;
    assign mem_write       = w_busy & r_write;
    assign mem_address     = w_busy ? r_addr  : 32'h0;
    assign mem_wdata       = w_busy ? r_wdata : 32'h0;
    assign mem_byte_enable = w_busy ? r_mask  : 4'b0000;
    assign stall_o         = w_issue | w_busy;
    assign done_o          = (r_state == DONE);
    assign rdata_o         = r_rdata;
    assign byte_enable_o   = r_be;
    assign misaligned_o    = w_idle & req_valid & w_misaligned;
    assign timeout_o       = w_timeout;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-lane reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_write, flush, mem_resp;
    logic [2:0]  funct3;
    logic [31:0] addr, rs2_data, mem_rdata;
    logic        mem_read, mem_write, stall_o, done_o, misaligned_o, timeout_o;
    logic [31:0] mem_address, mem_wdata, rdata_o;
    logic [3:0]  mem_byte_enable, byte_enable_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] m_rdata = 32'h0;
    logic [3:0]  m_be    = 4'h0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .funct3(funct3), .addr(addr), .rs2_data(rs2_data), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .byte_enable_o(byte_enable_o), .misaligned_o(misaligned_o), .timeout_o(timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int sz = acc_size(f3);
        return (sz > 1) && ((a % sz) != 0);
    endfunction

    function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] m = 4'h0;
        int off = int'(a % 4);
        for (int i = 0; i < acc_size(f3); i++)
            if (off + i < 4) m[off + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] d);
        logic [31:0] w = 32'h0;
        int off = int'(a % 4);
        for (int i = 0; i < acc_size(f3); i++)
            if (off + i < 4) w[8*(off+i) +: 8] = d[8*i +: 8];
        return w;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_rd"},    32'(mem_read),  32'h0);
        check({tag, "_wr"},    32'(mem_write), 32'h0);
        check({tag, "_stall"}, 32'(stall_o),   32'h0);
        check({tag, "_done"},  32'(done_o),    32'h0);
    endtask

    // lat = BUSY cycle carrying mem_resp; flush_at = BUSY cycle with flush (-1 none)
    task automatic txn(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int lat, input logic [31:0] rd,
                       input int flush_at);
        logic [3:0]  m;
        logic [31:0] wd;
        bit          mis, fl;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; rs2_data = d;
        flush = 1'b0; mem_resp = 1'b0;
        #1;
        mis = ref_misaligned(f3, a);
        m   = mis ? 4'h0 : ref_mask(f3, a);
        wd  = ref_wdata(f3, a, d);
        check("misaligned", 32'(misaligned_o), 32'(mis));
        if (m == 4'h0) begin
            check("stall_rej", 32'(stall_o), 32'h0);
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check_quiet("after_rej");
            return;
        end
        check("stall_issue", 32'(stall_o), 32'h1);
        fl = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom);
            funct3 = 3'($urandom); addr = $urandom; rs2_data = $urandom;
            flush = (k == flush_at); mem_resp = (k == lat);
            mem_rdata = (k == lat) ? rd : $urandom;
            #1;
            fl |= flush;
            check("busy_rd",    32'(mem_read),        32'(!wr));
            check("busy_wr",    32'(mem_write),       32'(wr));
            check("busy_addr",  mem_address,          {a[31:2], 2'b00});
            check("busy_wdata", mem_wdata,            wd);
            check("busy_be",    32'(mem_byte_enable), 32'(m));
            check("busy_stall", 32'(stall_o),         32'h1);
            check("busy_done",  32'(done_o),          32'h0);
            check("busy_tmo",   32'(timeout_o),       32'h0);
            check("busy_mis",   32'(misaligned_o),    32'h0);
        end
        @(negedge clk);
        mem_resp = 1'b0; flush = 1'b0;
        req_valid = !fl; req_write = wr; funct3 = f3; addr = a; rs2_data = d;
        #1;
        if (fl) begin
            check_quiet("flushed");
        end else begin
            m_rdata = wr ? 32'h0 : rd;
            m_be    = m;
            check("done",       32'(done_o),    32'h1);
            check("done_stall", 32'(stall_o),   32'h0);
            check("done_rd",    32'(mem_read),  32'h0);
            check("done_wr",    32'(mem_write), 32'h0);
        end
        check("rdata", rdata_o,              m_rdata);
        check("be",    32'(byte_enable_o),   32'(m_be));
    endtask

    initial begin
        logic [2:0] f3_tab [8];
        logic [2:0] f3;
        logic [31:0] a;
        bit wr;
        int lat, fa;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'd0; addr = 32'h0;
        rs2_data = 32'h0; flush = 1'b0; mem_resp = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");
        check("reset_rdata", rdata_o, 32'h0);
        check("reset_be", 32'(byte_enable_o), 32'h0);
        rst = 1'b0;

        txn(1'b1, 3'd0, 32'h1003, 32'hAABBCCDD, 4, 32'h0, -1);
        txn(1'b1, 3'd1, 32'h2002, 32'h00001234, 2, 32'h0, -1);
        txn(1'b0, 3'd5, 32'h2002, 32'h0, 2, 32'h12340000, -1);
        txn(1'b0, 3'd2, 32'h3001, 32'h0, 1, 32'h0, -1);
        txn(1'b0, 3'd1, 32'h3003, 32'h0, 1, 32'h0, -1);
        txn(1'b0, 3'd0, 32'h4000, 32'h0, 1, 32'hCAFEF00D, -1);
        txn(1'b1, 3'd2, 32'h4004, 32'h55667788, 1, 32'h0, -1);
        txn(1'b0, 3'd2, 32'h5000, 32'h0, 3, 32'h99999999, 1);
        txn(1'b1, 3'd0, 32'h6001, 32'h000000EE, 8, 32'h0, -1);

        for (int n = 0; n < 40; n++) begin
            f3  = f3_tab[$urandom_range(0, 7)];
            wr  = 1'($urandom) && (f3 <= 3'd2);
            a   = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            lat = $urandom_range(1, 7);
            fa  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat) : -1;
            txn(wr, f3, a, $urandom, lat, $urandom, fa);
        end

        // flush in IDLE blocks issue
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'd2; addr = 32'h7000; flush = 1'b1;
        #1;
        check("flush_idle_stall", 32'(stall_o), 32'h0);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1;
        check_quiet("flush_idle");

        // late mem_resp in IDLE is ignored
        @(negedge clk);
        mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_resp = 1'b0;
        #1;
        check_quiet("late_resp");
        check("late_resp_rdata", rdata_o, m_rdata);

        // timeout after 8 BUSY cycles without resp
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'd2; addr = 32'h8000;
        #1;
        check("tmo_issue", 32'(stall_o), 32'h1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check("tmo_rd", 32'(mem_read), 32'h1);
            check("tmo_pulse", 32'(timeout_o), 32'(k == 8));
        end
        @(negedge clk);
        #1;
        check_quiet("after_tmo");
        check("after_tmo_pulse", 32'(timeout_o), 32'h0);

        // reset mid-BUSY
        txn(1'b0, 3'd2, 32'h9000, 32'h0, 1, 32'h13572468, -1);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; funct3 = 3'd2; addr = 32'h9004;
        rs2_data = 32'h11223344;
        repeat (2) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        #1;
        check("pre_rst_wr", 32'(mem_write), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_quiet("rst_busy");
        check("rst_addr", mem_address, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_be", 32'(byte_enable_o), 32'h0);
        rst = 1'b0;
        m_rdata = 32'h0;
        m_be = 4'h0;
        txn(1'b0, 3'd4, 32'hA001, 32'h0, 2, 32'h00AB0000, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
